// File: rtl/req_burst_if.sv
// -----------------------------------------------------------------------------
// req_burst_if
// Bundles the per-agent burst handshake between four requesting agents / the
// grant arbiter and the req_burst_ctrl request stage.
//
// Parameters:
//   LEN_W   width of each burst length field
//
// Signals (N = 0..3):
//   start_N    agent -> ctrl   one-cycle burst start pulse
//   len_N      agent -> ctrl   beat count, sampled with start_N
//   gnt_N      arb   -> ctrl   grant for agent N
//   req_N      ctrl  -> arb    level request
//   beat_N     ctrl  -> agent  one cycle per granted beat
//   done_N     ctrl  -> agent  burst-complete pulse
//   busy_N     ctrl  -> agent  channel not idle
//   timeout_N  ctrl  -> agent  request abort pulse
//
// Modports:
//   master  agent/arbiter side (drives start, len, gnt)
//   slave   req_burst_ctrl side (drives req, beat, done, busy, timeout)
// -----------------------------------------------------------------------------
interface req_burst_if #(
  parameter int unsigned LEN_W = 4
);

  logic             start_0, start_1, start_2, start_3;
  logic [LEN_W-1:0] len_0, len_1, len_2, len_3;
  logic             gnt_0, gnt_1, gnt_2, gnt_3;

  logic             req_0, req_1, req_2, req_3;
  logic             beat_0, beat_1, beat_2, beat_3;
  logic             done_0, done_1, done_2, done_3;
  logic             busy_0, busy_1, busy_2, busy_3;
  logic             timeout_0, timeout_1, timeout_2, timeout_3;

  modport master (
    output start_0, start_1, start_2, start_3,
    output len_0, len_1, len_2, len_3,
    output gnt_0, gnt_1, gnt_2, gnt_3,
    input  req_0, req_1, req_2, req_3,
    input  beat_0, beat_1, beat_2, beat_3,
    input  done_0, done_1, done_2, done_3,
    input  busy_0, busy_1, busy_2, busy_3,
    input  timeout_0, timeout_1, timeout_2, timeout_3
  );

  modport slave (
    input  start_0, start_1, start_2, start_3,
    input  len_0, len_1, len_2, len_3,
    input  gnt_0, gnt_1, gnt_2, gnt_3,
    output req_0, req_1, req_2, req_3,
    output beat_0, beat_1, beat_2, beat_3,
    output done_0, done_1, done_2, done_3,
    output busy_0, busy_1, busy_2, busy_3,
    output timeout_0, timeout_1, timeout_2, timeout_3
  );

endinterface

// File: rtl/req_burst_ctrl.sv
// -----------------------------------------------------------------------------
// req_burst_ctrl
// Upstream request stage for the 4-agent grant arbiter. Each agent posts a
// burst as a start pulse plus a beat count; the channel raises a level request,
// counts granted beats, drops the request after the last beat and then holds
// it low for GAP cycles before accepting another start. Channels are fully
// independent and share only clock and reset. All outputs are registered.
//
// Parameters:
//   LEN_W    width of burst length (max burst 2^LEN_W-1 beats)
//   GAP      request-low cycles after a burst before a new start (>= 1)
//   TIMEOUT  ungranted REQ cycles before abort (only with REQ_TIMEOUT_EN)
//
// Ports:
//   clock    rising-edge clock
//   reset    synchronous, active-high reset
//   bus      req_burst_if.slave: start/len/gnt in, req/beat/done/busy/timeout out
//
// Compile-time option:
//   REQ_TIMEOUT_EN  when defined, each channel aborts a request that waits
//                   TIMEOUT cycles without a first grant (timeout_N pulse).
//                   When undefined, REQ waits forever and timeout_N is 0.
// -----------------------------------------------------------------------------
module req_burst_ctrl #(
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned GAP     = 2
`ifdef REQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 16
`endif
) (
  input  logic       clock,
  input  logic       reset,
  req_burst_if.slave bus
);

  localparam int unsigned NumCh = 4;
  localparam int unsigned GapW  = $clog2(GAP + 1);
`ifdef REQ_TIMEOUT_EN
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
`endif

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StXfer,
    StGap
  } state_e;

  // Interface fan-in to indexable vectors
  logic [NumCh-1:0] start_v;
  logic [NumCh-1:0] gnt_v;
  logic [LEN_W-1:0] len_v [NumCh];

  assign start_v  = {bus.start_3, bus.start_2, bus.start_1, bus.start_0};
  assign gnt_v    = {bus.gnt_3, bus.gnt_2, bus.gnt_1, bus.gnt_0};
  assign len_v[0] = bus.len_0;
  assign len_v[1] = bus.len_1;
  assign len_v[2] = bus.len_2;
  assign len_v[3] = bus.len_3;

  // Per-channel registered outputs, collected for the interface fan-out
  logic [NumCh-1:0] req_v;
  logic [NumCh-1:0] beat_v;
  logic [NumCh-1:0] done_v;
  logic [NumCh-1:0] busy_v;
  logic [NumCh-1:0] timeout_v;

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    state_e           state_q;
    logic [LEN_W-1:0] remaining_q;
    logic [GapW-1:0]  gap_q;
    logic             req_q;
    logic             beat_q;
    logic             done_q;
    logic             busy_q;
    logic             timeout_q;
`ifdef REQ_TIMEOUT_EN
    logic [WaitW-1:0] wait_q;
`endif

    always_ff @(posedge clock) begin
      if (reset) begin
        state_q     <= StIdle;
        remaining_q <= '0;
        gap_q       <= '0;
        req_q       <= 1'b0;
        beat_q      <= 1'b0;
        done_q      <= 1'b0;
        busy_q      <= 1'b0;
        timeout_q   <= 1'b0;
`ifdef REQ_TIMEOUT_EN
        wait_q      <= '0;
`endif
      end else begin
        // Pulse outputs default low every cycle
        beat_q    <= 1'b0;
        done_q    <= 1'b0;
        timeout_q <= 1'b0;

        case (state_q)
          StIdle: begin
            if (start_v[c]) begin
              if (len_v[c] != '0) begin
                state_q     <= StReq;
                remaining_q <= len_v[c];
                req_q       <= 1'b1;
                busy_q      <= 1'b1;
`ifdef REQ_TIMEOUT_EN
                wait_q      <= '0;
`endif
              end else begin
                // Zero-length burst completes without ever requesting
                done_q <= 1'b1;
              end
            end
          end

          StReq, StXfer: begin
            // start_v is deliberately ignored here: a busy channel keeps its burst
            if (gnt_v[c]) begin
              beat_q      <= 1'b1;
              remaining_q <= remaining_q - LEN_W'(1);
              if (remaining_q == LEN_W'(1)) begin
                done_q  <= 1'b1;
                req_q   <= 1'b0;
                state_q <= StGap;
                gap_q   <= GapW'(GAP);
              end else begin
                state_q <= StXfer;
              end
            end
`ifdef REQ_TIMEOUT_EN
            else if (state_q == StReq) begin
              // Only the wait for the first grant is bounded; XFER pauses are not
              if (wait_q == WaitW'(TIMEOUT - 1)) begin
                req_q       <= 1'b0;
                timeout_q   <= 1'b1;
                remaining_q <= '0;
                state_q     <= StGap;
                gap_q       <= GapW'(GAP);
              end else begin
                wait_q <= wait_q + WaitW'(1);
              end
            end
`endif
          end

          StGap: begin
            // Late grants from the registered arbiter land here and are dropped
            gap_q <= gap_q - GapW'(1);
            if (gap_q == GapW'(1)) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end

          default: begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end

    assign req_v[c]     = req_q;
    assign beat_v[c]    = beat_q;
    assign done_v[c]    = done_q;
    assign busy_v[c]    = busy_q;
    assign timeout_v[c] = timeout_q;
  end

  assign bus.req_0     = req_v[0];
  assign bus.req_1     = req_v[1];
  assign bus.req_2     = req_v[2];
  assign bus.req_3     = req_v[3];
  assign bus.beat_0    = beat_v[0];
  assign bus.beat_1    = beat_v[1];
  assign bus.beat_2    = beat_v[2];
  assign bus.beat_3    = beat_v[3];
  assign bus.done_0    = done_v[0];
  assign bus.done_1    = done_v[1];
  assign bus.done_2    = done_v[2];
  assign bus.done_3    = done_v[3];
  assign bus.busy_0    = busy_v[0];
  assign bus.busy_1    = busy_v[1];
  assign bus.busy_2    = busy_v[2];
  assign bus.busy_3    = busy_v[3];
  assign bus.timeout_0 = timeout_v[0];
  assign bus.timeout_1 = timeout_v[1];
  assign bus.timeout_2 = timeout_v[2];
  assign bus.timeout_3 = timeout_v[3];

endmodule

// File: tb/tb_req_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_req_burst_ctrl
// Directed bench for req_burst_ctrl. A per-channel burst model (remaining
// beats, cool-down cycles, first-grant wait) predicts every output; each
// cycle all outputs are compared against it, and per-test event counts are
// also checked against hand-computed constants.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_req_burst_ctrl;

  localparam int unsigned LEN_W = 4;
  localparam int unsigned GAP   = 2;
`ifdef REQ_TIMEOUT_EN
  localparam int unsigned TIMEOUT = 16;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [3:0]       start = '0;
  logic [3:0]       gnt   = '0;
  logic [LEN_W-1:0] len [4];
  logic [3:0]       req, beat, done, busy, tmo;

  req_burst_if #(.LEN_W(LEN_W)) bus ();

  assign bus.start_0 = start[0];
  assign bus.start_1 = start[1];
  assign bus.start_2 = start[2];
  assign bus.start_3 = start[3];
  assign bus.len_0   = len[0];
  assign bus.len_1   = len[1];
  assign bus.len_2   = len[2];
  assign bus.len_3   = len[3];
  assign bus.gnt_0   = gnt[0];
  assign bus.gnt_1   = gnt[1];
  assign bus.gnt_2   = gnt[2];
  assign bus.gnt_3   = gnt[3];
  assign req  = {bus.req_3, bus.req_2, bus.req_1, bus.req_0};
  assign beat = {bus.beat_3, bus.beat_2, bus.beat_1, bus.beat_0};
  assign done = {bus.done_3, bus.done_2, bus.done_1, bus.done_0};
  assign busy = {bus.busy_3, bus.busy_2, bus.busy_1, bus.busy_0};
  assign tmo  = {bus.timeout_3, bus.timeout_2, bus.timeout_1, bus.timeout_0};

  req_burst_ctrl #(
    .LEN_W(LEN_W),
    .GAP  (GAP)
`ifdef REQ_TIMEOUT_EN
    ,
    .TIMEOUT(TIMEOUT)
`endif
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    int rem;     // beats still owed (>0 means requesting)
    int cool;    // cycles before a new start is accepted
    int waited;  // ungranted cycles before the first beat
    bit got;     // at least one beat granted
    bit req;
    bit beat;
    bit done;
    bit busy;
    bit tmo;
  } mstate_t;

  mstate_t ms [4];

  function automatic mstate_t model_next(mstate_t s, bit rst, bit st, int ln, bit g);
    mstate_t n;
    n      = s;
    n.beat = 1'b0;
    n.done = 1'b0;
    n.tmo  = 1'b0;
    if (rst) begin
      n = '0;
      return n;
    end
    if (n.rem > 0) begin
      if (g) begin
        n.beat = 1'b1;
        n.got  = 1'b1;
        n.rem  = n.rem - 1;
        if (n.rem == 0) begin
          n.done = 1'b1;
          n.cool = GAP;
        end
      end
`ifdef REQ_TIMEOUT_EN
      else if (!n.got) begin
        n.waited = n.waited + 1;
        if (n.waited == TIMEOUT) begin
          n.rem  = 0;
          n.tmo  = 1'b1;
          n.cool = GAP;
        end
      end
`endif
    end else if (n.cool > 0) begin
      n.cool = n.cool - 1;
    end else if (st) begin
      if (ln == 0) begin
        n.done = 1'b1;
      end else begin
        n.rem    = ln;
        n.waited = 0;
        n.got    = 1'b0;
      end
    end
    n.req  = (n.rem > 0);
    n.busy = (n.rem > 0) || (n.cool > 0);
    return n;
  endfunction

  always @(posedge clock) begin
    for (int c = 0; c < 4; c++) begin
      ms[c] <= model_next(ms[c], reset, start[c], int'(len[c]), gnt[c]);
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int beat_cnt [4] = '{default: 0};
  int done_cnt [4] = '{default: 0};
  int tmo_cnt  [4] = '{default: 0};
  int req_cyc  [4] = '{default: 0};
  int m_beat   [4] = '{default: 0};
  int done_at  [4] = '{default: 0};
  int idle_at  [4] = '{default: 0};
  bit busy_prev [4] = '{default: 1'b0};

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one cycle and compare every output against the model
  task automatic step();
    @(negedge clock);
    cyc++;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("req_%0d@%0d", c, cyc), int'(req[c]), int'(ms[c].req));
      chk($sformatf("beat_%0d@%0d", c, cyc), int'(beat[c]), int'(ms[c].beat));
      chk($sformatf("done_%0d@%0d", c, cyc), int'(done[c]), int'(ms[c].done));
      chk($sformatf("busy_%0d@%0d", c, cyc), int'(busy[c]), int'(ms[c].busy));
      chk($sformatf("timeout_%0d@%0d", c, cyc), int'(tmo[c]), int'(ms[c].tmo));
      if (beat[c] === 1'b1) beat_cnt[c]++;
      if (done[c] === 1'b1) begin
        done_cnt[c]++;
        done_at[c] = cyc;
      end
      if (tmo[c] === 1'b1) tmo_cnt[c]++;
      if (req[c] === 1'b1) req_cyc[c]++;
      if (ms[c].beat) m_beat[c]++;
      if (busy_prev[c] && busy[c] === 1'b0) idle_at[c] = cyc;
      busy_prev[c] = (busy[c] === 1'b1);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int b0 [4], d0 [4], r0 [4], t0 [4], mb0 [4];

  task automatic snap();
    for (int c = 0; c < 4; c++) begin
      b0[c]  = beat_cnt[c];
      d0[c]  = done_cnt[c];
      r0[c]  = req_cyc[c];
      t0[c]  = tmo_cnt[c];
      mb0[c] = m_beat[c];
    end
  endtask

  initial begin
    for (int c = 0; c < 4; c++) len[c] = '0;

    // Reset, then idle
    reset = 1'b1;
    steps(3);
    reset = 1'b0;
    snap();
    steps(10);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("idle_activity_%0d", c),
          beat_cnt[c] + done_cnt[c] + req_cyc[c] + tmo_cnt[c] - b0[c] - d0[c] - r0[c] - t0[c], 0);
    end

    // Channel 0: len 3, grant one cycle after req and held
    snap();
    start[0] = 1'b1;
    len[0]   = 4'd3;
    step();
    start[0] = 1'b0;
    step();
    gnt[0] = 1'b1;
    steps(4);
    gnt[0] = 1'b0;
    steps(4);
    chk("ch0_beats", beat_cnt[0] - b0[0], 3);
    chk("ch0_model_beats", m_beat[0] - mb0[0], 3);
    chk("ch0_dones", done_cnt[0] - d0[0], 1);
    chk("ch0_req_cycles", req_cyc[0] - r0[0], 4);
    chk("ch0_done_to_idle", idle_at[0] - done_at[0], 2);

    // Channel 2: len 4, grant pattern 1,0,1,1,0,1
    snap();
    start[2] = 1'b1;
    len[2]   = 4'd4;
    step();
    start[2] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      gnt[2] = (i == 1 || i == 4) ? 1'b0 : 1'b1;
      step();
    end
    gnt[2] = 1'b0;
    steps(4);
    chk("ch2_beats", beat_cnt[2] - b0[2], 4);
    chk("ch2_model_beats", m_beat[2] - mb0[2], 4);
    chk("ch2_dones", done_cnt[2] - d0[2], 1);
    chk("ch2_req_cycles", req_cyc[2] - r0[2], 6);

    // Channel 1: zero length, then a start while busy
    snap();
    start[1] = 1'b1;
    len[1]   = 4'd0;
    step();
    start[1] = 1'b0;
    chk("ch1_zero_done", int'(done[1]), 1);
    steps(2);
    chk("ch1_zero_req", req_cyc[1] - r0[1], 0);
    snap();
    start[1] = 1'b1;
    len[1]   = 4'd2;
    step();
    start[1] = 1'b0;
    step();
    start[1] = 1'b1;
    len[1]   = 4'd5;
    step();
    start[1] = 1'b0;
    gnt[1]   = 1'b1;
    steps(3);
    gnt[1] = 1'b0;
    steps(6);
    chk("ch1_busy_start_beats", beat_cnt[1] - b0[1], 2);
    chk("ch1_busy_start_dones", done_cnt[1] - d0[1], 1);

    // All channels at once, grants given serially, each held one cycle into GAP
    snap();
    start = 4'hf;
    for (int c = 0; c < 4; c++) len[c] = 4'd2;
    step();
    start = 4'h0;
    chk("all_req_together", int'(req), 15);
    for (int c = 0; c < 4; c++) begin
      gnt[c] = 1'b1;
      steps(3);
      gnt[c] = 1'b0;
    end
    steps(4);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("all_beats_%0d", c), beat_cnt[c] - b0[c], 2);
      chk($sformatf("all_dones_%0d", c), done_cnt[c] - d0[c], 1);
    end

    // Reset mid-burst on channel 3 at beat 2 of 5
    snap();
    start[3] = 1'b1;
    len[3]   = 4'd5;
    step();
    start[3] = 1'b0;
    gnt[3]   = 1'b1;
    steps(2);
    reset = 1'b1;
    step();
    chk("rst_mid_req", int'(req[3]), 0);
    chk("rst_mid_busy", int'(busy[3]), 0);
    reset  = 1'b0;
    gnt[3] = 1'b0;
    steps(3);
    chk("rst_mid_beats", beat_cnt[3] - b0[3], 2);
    chk("rst_mid_dones", done_cnt[3] - d0[3], 0);

    // Channel 3: len 5 with grant held low
    snap();
    start[3] = 1'b1;
    len[3]   = 4'd5;
    step();
    start[3] = 1'b0;
    steps(20);
`ifdef REQ_TIMEOUT_EN
    chk("tmo_pulses", tmo_cnt[3] - t0[3], 1);
    chk("tmo_dones", done_cnt[3] - d0[3], 0);
    chk("tmo_req_cycles", req_cyc[3] - r0[3], 16);
    chk("tmo_busy_after", int'(busy[3]), 0);
`else
    chk("nogrant_tmo", tmo_cnt[3] - t0[3], 0);
    chk("nogrant_req_cycles", req_cyc[3] - r0[3], 21);
    chk("nogrant_dones", done_cnt[3] - d0[3], 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
